uart_tx_serializer: RTL and testbench

//   Upstream neighbour of the UART receiver: serializes one byte into a 10-bit UART frame
//   (start 0, D0..D7 LSB first, stop 1) and drives the serial line the receiver samples.
//   A parallel byte is accepted with a start/busy handshake. A per-bit baud counter holds each bit.

---
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serializes one byte into a UART frame: a start bit (0), D0..D7 LSB first,
//   and STOP_BITS stop bits (1). Each serial bit is held for CLKS_PER_BIT clocks.
//   A byte is accepted on the edge where tx_start=1 and busy=0.
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   tx_start  send request, sampled only while idle
//   tx_data   byte to send, captured on the accepting edge
//   Tx        registered serial line, idles high
//   busy      high while a frame is in flight
//   done      one-cycle pulse on the first idle cycle after the last stop bit
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       Tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned     CW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [7:0]    shift_q,   shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0] baud_q,    baud_d;
  logic          tx_q,      tx_d;
  logic          busy_q,    busy_d;
  logic          done_q,    done_d;
  logic          bit_end;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_end   = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d = S_START;
          shift_d = tx_data;
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = '0;
            tx_d      = 1'b1;
          end else begin
            // Tx is registered, so the next bit is taken from shift_q[1]
            // in the same cycle the register shifts.
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx1, busy1, done1;
  logic       tx4, busy4, done4;
  logic       tx2, busy2, done2;
  logic       tx_m, busy_m, done_m;
  int unsigned sel;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u_c1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx1), .busy(busy1), .done(done1));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_c4 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx4), .busy(busy4), .done(done4));
  uart_tx_serializer #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_c2s2 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .Tx(tx2), .busy(busy2), .done(done2));

  assign tx_m   = (sel == 0) ? tx1   : (sel == 1) ? tx4   : tx2;
  assign busy_m = (sel == 0) ? busy1 : (sel == 1) ? busy4 : busy2;
  assign done_m = (sel == 0) ? done1 : (sel == 1) ? done4 : done2;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    int unsigned sel;
    logic [7:0]  data;
    logic [9:0]  frame;   // expected line bits, index 0 sent first
  } vec_t;

  exp_t sb_q[$];
  logic txlog[$];
  int unsigned busy_cnt;
  int n_vec = 0;
  int n_err = 0;

  function automatic int unsigned cpb_of(int unsigned s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 2;
  endfunction

  function automatic int unsigned sb_of(int unsigned s);
    return (s == 2) ? 2 : 1;
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(logic t, logic b, logic d);
    exp_t e;
    e.tx = t; e.busy = b; e.done = d;
    sb_q.push_back(e);
  endtask

  task automatic push_frame(int unsigned s, logic [9:0] frame, bit idle_after);
    int unsigned cpb = cpb_of(s);
    int unsigned reps;
    for (int unsigned i = 0; i < 10; i++) begin
      reps = (i == 9) ? sb_of(s) * cpb : cpb;
      for (int unsigned r = 0; r < reps; r++) push_exp(frame[i], 1'b1, 1'b0);
    end
    push_exp(1'b1, 1'b0, 1'b1);
    if (idle_after) push_exp(1'b1, 1'b0, 1'b0);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    txlog.push_back(tx_m);
    if (busy_m) busy_cnt++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cycle {Tx,busy,done}", {6'b0, tx_m, busy_m, done_m}, {6'b0, e.tx, e.busy, e.done});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 500) begin
      step();
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain timeout", 9'(sb_q.size()), 9'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    tx_start = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset hold", {tx1, busy1, done1, tx4, busy4, done4, tx2, busy2, done2},
            9'b100_100_100);
    end
    tx_start = 1'b0;
    reset    = 1'b1;
    push_exp(1'b1, 1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic send_vec(vec_t v);
    int unsigned cpb = cpb_of(v.sel);
    logic [7:0] dec;
    sel      = v.sel;
    txlog.delete();
    busy_cnt = 0;
    tx_data  = v.data;
    tx_start = 1'b1;
    push_frame(v.sel, v.frame, 1'b1);
    step();
    tx_start = 1'b0;
    drain();
    check("busy cycles", 9'(busy_cnt), 9'((9 + sb_of(v.sel)) * cpb));
    dec = '0;
    if (txlog.size() >= 10 * cpb) begin
      for (int unsigned j = 0; j < 8; j++) dec[j] = txlog[(j + 1) * cpb + cpb / 2];
    end
    check("decoded byte", {1'b0, dec}, {1'b0, v.data});
  endtask

  vec_t vecs[6];

  initial begin
    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = '0;
    sel      = 0;

    vecs[0] = '{sel: 0, data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{sel: 1, data: 8'h3C, frame: 10'b1001111000};
    vecs[2] = '{sel: 0, data: 8'h81, frame: 10'b1100000010};
    vecs[3] = '{sel: 0, data: 8'h00, frame: 10'b1000000000};
    vecs[4] = '{sel: 2, data: 8'h5A, frame: 10'b1010110100};
    vecs[5] = '{sel: 1, data: 8'hFF, frame: 10'b1111111110};

    do_reset();
    foreach (vecs[i]) begin
      do_reset();
      send_vec(vecs[i]);
    end

    // tx_start pulsed mid-frame with new data must be ignored
    do_reset();
    sel      = 1;
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    push_frame(1, 10'b1001111000, 1'b1);
    step();
    tx_start = 1'b0;
    step();
    step();
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    tx_data  = 8'h00;
    drain();

    // reset asserted mid-frame aborts immediately without a done pulse
    do_reset();
    sel      = 0;
    tx_data  = 8'h00;
    tx_start = 1'b1;
    push_frame(0, 10'b1000000000, 1'b0);
    step();
    tx_start = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    #1;
    check("abort immediate", {6'b0, tx_m, busy_m, done_m}, 9'b100);
    sb_q.delete();
    @(posedge clk);
    #1;
    check("abort held", {6'b0, tx_m, busy_m, done_m}, 9'b100);
    reset = 1'b1;
    repeat (3) push_exp(1'b1, 1'b0, 1'b0);
    repeat (3) step();
    send_vec('{sel: 0, data: 8'h00, frame: 10'b1000000000});

    // tx_start held high: two frames, second sampled in the done cycle
    do_reset();
    sel      = 0;
    tx_data  = 8'h12;
    tx_start = 1'b1;
    push_frame(0, 10'b1000100100, 1'b0);
    push_frame(0, 10'b1001101000, 1'b1);
    step();
    tx_data = 8'h34;
    repeat (10) step();
    step();
    tx_start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
